// File: rtl/alu_md_unit.sv
// Execute-stage ALU with base RV32I ops and an optional iterative RV32M multiply/divide engine.
// Base ops finish combinationally; M ops stall through busy_o until the registered result is ready.
module alu_md_unit #(
    parameter int XLEN  = 32,
    parameter bit M_EXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [1:0]      ALUOp,
    input  logic            opb5,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush_i,
    output logic [3:0]      ALUControl,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            valid_o,
    output logic            busy_o
);
    localparam int SW = $clog2(XLEN);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] base_result;
    logic            md_op;
    logic            md_idle;
    logic            md_busy;
    logic            md_valid;
    logic [XLEN-1:0] md_result;

    always_comb begin
        ALUControl = 4'b0000;
        case (ALUOp)
            2'b00: ALUControl = 4'b0000;
            2'b01: ALUControl = 4'b0001;
            default: begin
                case (funct3)
                    3'b000: ALUControl = (funct7b5 & opb5) ? 4'b0001 : 4'b0000;
                    3'b001: ALUControl = 4'b0100;
                    3'b010: ALUControl = 4'b0101;
                    3'b011: ALUControl = 4'b1000;
                    3'b100: ALUControl = 4'b0110;
                    3'b101: ALUControl = funct7b5 ? 4'b1111 : 4'b0111;
                    3'b110: ALUControl = 4'b0011;
                    default: ALUControl = 4'b0010;
                endcase
            end
        endcase
    end

    assign shamt = srcB[SW-1:0];

    always_comb begin
        base_result = '0;
        case (ALUControl)
            4'b0000: base_result = srcA + srcB;
            4'b0001: base_result = srcA - srcB;
            4'b0100: base_result = srcA << shamt;
            4'b0101: base_result = XLEN'($signed(srcA) < $signed(srcB));
            4'b1000: base_result = XLEN'(srcA < srcB);
            4'b0110: base_result = srcA ^ srcB;
            4'b1111: base_result = $signed(srcA) >>> shamt;
            4'b0111: base_result = srcA >> shamt;
            4'b0011: base_result = srcA | srcB;
            4'b0010: base_result = srcA & srcB;
            default: base_result = '0;
        endcase
    end

    assign md_op = M_EXT & (ALUOp == 2'b10) & opb5 & funct7b0;

    generate
        if (M_EXT) begin : g_md
            localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

            logic [1:0]        state_reg;
            logic [SW-1:0]     count_reg;
            logic [2:0]        op_reg;
            logic              neg_reg;
            logic [XLEN-1:0]   a_reg;
            logic [2*XLEN-1:0] prod_reg;
            logic [XLEN-1:0]   result_reg;

            logic              a_signed, b_signed, a_neg, b_neg, is_div;
            logic [XLEN-1:0]   abs_a, abs_b;
            logic              div_zero, div_ovf, special, accept;
            logic [XLEN-1:0]   special_result;
            logic [XLEN:0]     mul_sum, div_sh, div_diff;
            logic              div_take;
            logic [2*XLEN-1:0] mul_next, div_next, step_next, prod_fix;
            logic [XLEN-1:0]   quo_fix, rem_fix, final_result;

            // MULHSU treats only A as signed; DIVU/REMU/MULHU are fully unsigned.
            assign a_signed = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010)
                            | (funct3 == 3'b100) | (funct3 == 3'b110);
            assign b_signed = a_signed & (funct3 != 3'b010);
            assign a_neg    = a_signed & srcA[XLEN-1];
            assign b_neg    = b_signed & srcB[XLEN-1];
            assign abs_a    = a_neg ? -srcA : srcA;
            assign abs_b    = b_neg ? -srcB : srcB;
            assign is_div   = funct3[2];

            assign div_zero = (srcB == '0);
            assign div_ovf  = ~funct3[0] & (srcA == MIN) & (srcB == '1);
            assign special  = is_div & (div_zero | div_ovf);
            assign special_result = funct3[1] ? (div_zero ? srcA : '0)
                                              : (div_zero ? '1 : MIN);

            assign accept = (state_reg == IDLE) & valid_i & md_op & ~flush_i;

            // Multiply: add multiplicand into the high half, then shift the whole product right.
            assign mul_sum  = {1'b0, prod_reg[2*XLEN-1:XLEN]} + (prod_reg[0] ? {1'b0, a_reg} : '0);
            assign mul_next = {mul_sum, prod_reg[XLEN-1:1]};
            // Restoring divide: {remainder, quotient} shifts left, quotient bit enters at bit 0.
            assign div_sh   = prod_reg[2*XLEN-1:XLEN-1];
            assign div_diff = div_sh - {1'b0, a_reg};
            assign div_take = ~div_diff[XLEN];
            assign div_next = {(div_take ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                               prod_reg[XLEN-2:0], div_take};
            assign step_next = op_reg[2] ? div_next : mul_next;

            assign prod_fix = neg_reg ? -step_next : step_next;
            assign quo_fix  = neg_reg ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
            assign rem_fix  = neg_reg ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];

            always_comb begin
                final_result = '0;
                case (op_reg)
                    3'b000:          final_result = prod_fix[XLEN-1:0];
                    3'b001, 3'b010,
                    3'b011:          final_result = prod_fix[2*XLEN-1:XLEN];
                    3'b100, 3'b101:  final_result = quo_fix;
                    default:         final_result = rem_fix;
                endcase
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg  <= IDLE;
                    count_reg  <= '0;
                    op_reg     <= '0;
                    neg_reg    <= 1'b0;
                    a_reg      <= '0;
                    prod_reg   <= '0;
                    result_reg <= '0;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            if (accept) begin
                                if (special) begin
                                    result_reg <= special_result;
                                    state_reg  <= DONE;
                                end else begin
                                    op_reg    <= funct3;
                                    neg_reg   <= (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
                                    a_reg     <= is_div ? abs_b : abs_a;
                                    prod_reg  <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
                                    count_reg <= SW'(XLEN - 1);
                                    state_reg <= CALC;
                                end
                            end
                        end
                        CALC: begin
                            if (flush_i) begin
                                state_reg <= IDLE;
                            end else begin
                                prod_reg  <= step_next;
                                count_reg <= count_reg - SW'(1);
                                if (count_reg == '0) begin
                                    result_reg <= final_result;
                                    state_reg  <= DONE;
                                end
                            end
                        end
                        default: state_reg <= IDLE;
                    endcase
                end
            end

            assign md_idle   = (state_reg == IDLE);
            assign md_busy   = accept | ((state_reg == CALC) & ~flush_i);
            assign md_valid  = (state_reg == DONE) & ~flush_i;
            assign md_result = result_reg;
        end else begin : g_no_md
            assign md_idle   = 1'b1;
            assign md_busy   = 1'b0;
            assign md_valid  = 1'b0;
            assign md_result = '0;
        end
    endgenerate

    assign result_o = md_idle ? base_result : md_result;
    assign zero_o   = (result_o == '0);
    assign valid_o  = rst_n & (md_idle ? (valid_i & ~md_op) : md_valid);
    assign busy_o   = rst_n & md_busy;

endmodule

// File: tb/tb_alu_md_unit.sv
// Scoreboard bench for alu_md_unit: stimulus queues expected results, a monitor pops them on valid_o.
module tb_alu_md_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [1:0]  ALUOp;
    logic        opb5;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        funct7b0;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        flush_i;
    logic [3:0]  ALUControl;
    logic [31:0] result_o;
    logic        zero_o;
    logic        valid_o;
    logic        busy_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] mon_exp;
    string       mon_name;

    alu_md_unit #(.XLEN(32), .M_EXT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ALUOp(ALUOp), .opb5(opb5),
        .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0), .srcA(srcA), .srcB(srcB),
        .flush_i(flush_i), .ALUControl(ALUControl), .result_o(result_o), .zero_o(zero_o),
        .valid_o(valid_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every valid_o is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got result 0x%08h expected no output", result_o);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, result_o, mon_exp);
                check({mon_name, "_zero"}, 32'(zero_o), 32'(mon_exp == 32'h0));
                $display("txn %s result=0x%08h", mon_name, result_o);
            end
        end
    end

    task automatic run_base(input logic [1:0] aluop, input logic ob5, input logic [2:0] f3,
                            input logic f7b5, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] exp_ctrl, input logic [31:0] exp_res,
                            input string name);
        exp_q.push_back(exp_res);
        name_q.push_back(name);
        @(posedge clk); #1;
        valid_i = 1'b1; ALUOp = aluop; opb5 = ob5; funct3 = f3;
        funct7b5 = f7b5; funct7b0 = 1'b0; srcA = a; srcB = b;
        @(negedge clk);
        check({name, "_ctrl"}, 32'(ALUControl), 32'(exp_ctrl));
        check({name, "_valid"}, 32'(valid_o), 32'h1);
        check({name, "_busy"}, 32'(busy_o), 32'h0);
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    // Ends at the negedge of the valid cycle with inputs still held.
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input string name);
        int  lat;
        int  busy_cnt;
        bit  got;
        exp_q.push_back(exp_res);
        name_q.push_back(name);
        @(posedge clk); #1;
        valid_i = 1'b1; ALUOp = 2'b10; opb5 = 1'b1; funct3 = f3;
        funct7b5 = 1'b0; funct7b0 = 1'b1; srcA = a; srcB = b;
        lat = -1; busy_cnt = 0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
            if (valid_o) begin
                got = 1'b1;
                lat = c;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    endtask

    task automatic idle();
        @(posedge clk); #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic expect_no_valid(input string name);
        int cnt;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) cnt++;
        end
        check(name, 32'(cnt), 32'h0);
    endtask

    task automatic start_div();
        @(posedge clk); #1;
        valid_i = 1'b1; ALUOp = 2'b10; opb5 = 1'b1; funct3 = 3'b100;
        funct7b5 = 1'b0; funct7b0 = 1'b1; srcA = 32'hFFFF_FFF9; srcB = 32'd2;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; valid_i = 1'b1; ALUOp = 2'b00; opb5 = 1'b0; funct3 = 3'b000;
        funct7b5 = 1'b0; funct7b0 = 1'b0; srcA = 32'd5; srcB = 32'd7; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 32'(valid_o), 32'h0);
        check("reset_busy", 32'(busy_o), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        valid_i = 1'b0;

        // Base decode sweep
        run_base(2'b10, 1'b1, 3'b000, 1'b1, 32'd5, 32'd7, 4'b0001, 32'hFFFF_FFFE, "sub_rtype");
        run_base(2'b10, 1'b0, 3'b000, 1'b1, 32'd5, 32'd7, 4'b0000, 32'd12, "addi_f7b5");
        run_base(2'b00, 1'b0, 3'b000, 1'b0, 32'd5, 32'd7, 4'b0000, 32'd12, "aluop_add");
        run_base(2'b01, 1'b0, 3'b000, 1'b0, 32'd10, 32'd3, 4'b0001, 32'd7, "aluop_sub");
        run_base(2'b00, 1'b0, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'h0, "add_wrap");
        run_base(2'b10, 1'b1, 3'b001, 1'b0, 32'd1, 32'h3F, 4'b0100, 32'h8000_0000, "sll_shamt");
        run_base(2'b10, 1'b1, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0101, 32'd1, "slt");
        run_base(2'b10, 1'b1, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'b1000, 32'd0, "sltu");
        run_base(2'b10, 1'b1, 3'b100, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0110, 32'h0FF0_0FF0, "xor");
        run_base(2'b10, 1'b1, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 4'b1111, 32'hF800_0000, "sra");
        run_base(2'b10, 1'b1, 3'b101, 1'b0, 32'h8000_0000, 32'd4, 4'b0111, 32'h0800_0000, "srl");
        run_base(2'b10, 1'b1, 3'b110, 1'b0, 32'h0000_F0F0, 32'h0000_0F0F, 4'b0011, 32'h0000_FFFF, "or");
        run_base(2'b10, 1'b1, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0010, 32'hF000_F000, "and");

        // Iterative M ops
        run_md(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_neg7_2");
        run_md(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_neg7_2");
        run_md(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min_min");
        run_md(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max_max");
        run_md(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, "mulhsu_neg1_2");
        run_md(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
        run_md(3'b111, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
        run_md(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "divu_min_max");
        run_md(3'b000, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF4, 33, "mul_3_neg4");
        // Back-to-back: add presented in the cycle after DONE
        run_base(2'b00, 1'b0, 3'b000, 1'b0, 32'd20, 32'd22, 4'b0000, 32'd42, "add_after_mul");

        // Special divides
        run_md(3'b101, 32'd123, 32'd0, 32'hFFFF_FFFF, 1, "divu_by_zero");
        run_md(3'b110, 32'd9, 32'd0, 32'd9, 1, "rem_by_zero");
        run_md(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_overflow");
        run_md(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_overflow");
        idle();

        // Flush at cycle 10 of a DIV
        start_div();
        @(negedge clk);
        check("flush_accept_busy", 32'(busy_o), 32'h1);
        repeat (10) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        check("flush_c10_valid", 32'(valid_o), 32'h0);
        check("flush_c10_busy", 32'(busy_o), 32'h0);
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        check("flush_c11_busy", 32'(busy_o), 32'h0);
        expect_no_valid("flush_no_valid");

        // Flush in the would-be accept cycle
        start_div();
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_accept_blocked_busy", 32'(busy_o), 32'h0);
        check("flush_accept_blocked_valid", 32'(valid_o), 32'h0);
        idle();
        @(negedge clk);
        check("flush_accept_after_busy", 32'(busy_o), 32'h0);
        expect_no_valid("flush_accept_no_valid");

        // Reset mid-CALC
        start_div();
        @(negedge clk);
        check("rst_accept_busy", 32'(busy_o), 32'h1);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 32'(valid_o), 32'h0);
        check("rst_mid_busy", 32'(busy_o), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; valid_i = 1'b0;
        @(negedge clk);
        check("rst_after_busy", 32'(busy_o), 32'h0);
        check("rst_after_valid", 32'(valid_o), 32'h0);
        expect_no_valid("rst_no_valid");

        run_base(2'b00, 1'b0, 3'b000, 1'b0, 32'd1, 32'd2, 4'b0000, 32'd3, "add_after_reset");
        repeat (3) idle();
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
